// File: rtl/binary_game_pkg.sv
// Shared types and constants for the binary-guessing game blocks.
// LFSR_TAPS marks bits 15,13,12,10, i.e. taps 16,14,13,11.
package binary_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_JUDGE = 3'd3,
    ST_DONE  = 3'd4
  } judge_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Shift left, feeding the XOR of the tapped bits into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances on every clock edge once reset
// is released.
module lfsr16
  import binary_game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  // Sequence register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/round_judge_checker.sv
// Runtime property checks on round_judge outputs; attach alongside the DUT.
module round_judge_checker #(
  parameter int NUM_ROUNDS = 10
) (
  input logic       clk,
  input logic       rst_n,
  input logic       is_equal,
  input logic       is_miss,
  input logic       round_active,
  input logic       game_over,
  input logic [3:0] round_idx
);

  a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n) !(is_equal && is_miss));
  a_eq_single: assert property (@(posedge clk) disable iff (!rst_n) is_equal |=> !is_equal);
  a_miss_single: assert property (@(posedge clk) disable iff (!rst_n) is_miss |=> !is_miss);
  a_idx_bound: assert property (@(posedge clk) disable iff (!rst_n) round_idx <= 4'(NUM_ROUNDS));
  a_level_excl: assert property (@(posedge clk) disable iff (!rst_n) !(round_active && game_over));

endmodule

// File: rtl/round_judge.sv
// Round sequencer and guess judge for the binary-guessing game.
// Optional per-round timeout is enabled by defining ROUND_TIMEOUT_EN.
module round_judge
  import binary_game_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int NUM_ROUNDS     = 10,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             submit,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] target,
  output logic             is_equal,
  output logic             is_miss,
  output logic             round_active,
  output logic [3:0]       round_idx,
  output logic             game_over
);

  judge_state_t state;
  logic [15:0]  lfsr_q;
  logic         unused_bits;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  // Only the low WIDTH bits feed the target.
  assign unused_bits = ^{lfsr_q, (TIMEOUT_CYCLES > 0)};

`ifdef ROUND_TIMEOUT_EN
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  logic [TIMER_W-1:0] timer;
`endif

  // Game FSM with registered outputs; stop overrides everything but reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      target       <= '0;
      round_idx    <= 4'd0;
      is_equal     <= 1'b0;
      is_miss      <= 1'b0;
      round_active <= 1'b0;
      game_over    <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
      timer        <= '0;
`endif
    end else if (stop) begin
      state        <= ST_IDLE;
      round_idx    <= 4'd0;
      is_equal     <= 1'b0;
      is_miss      <= 1'b0;
      round_active <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      is_equal <= 1'b0;
      is_miss  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_LOAD;
            round_idx <= 4'd0;
            game_over <= 1'b0;
          end else begin
            state <= state;
          end
        end
        ST_LOAD: begin
          target       <= lfsr_q[WIDTH-1:0];
          state        <= ST_WAIT;
          round_active <= 1'b1;
`ifdef ROUND_TIMEOUT_EN
          timer        <= '0;
`endif
        end
        ST_WAIT: begin
          // A submit on the expiry cycle still gets its switches judged.
          if (submit) begin
            state        <= ST_JUDGE;
            round_active <= 1'b0;
            is_equal     <= (switches == target);
            is_miss      <= (switches != target);
            round_idx    <= round_idx + 4'd1;
          end
`ifdef ROUND_TIMEOUT_EN
          else if (timer == TIMER_LAST) begin
            state        <= ST_JUDGE;
            round_active <= 1'b0;
            is_miss      <= 1'b1;
            round_idx    <= round_idx + 4'd1;
          end else begin
            timer <= timer + 1'b1;
          end
`else
          else begin
            state <= ST_WAIT;
          end
`endif
        end
        ST_JUDGE: begin
          if (round_idx == 4'(NUM_ROUNDS)) begin
            state     <= ST_DONE;
            game_over <= 1'b1;
          end else begin
            state <= ST_LOAD;
          end
        end
        default: begin
          state        <= ST_IDLE;
          round_idx    <= 4'd0;
          round_active <= 1'b0;
          game_over    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_judge.sv
// Randomized self-checking bench for round_judge (WIDTH=4, NUM_ROUNDS=3,
// TIMEOUT_CYCLES=20); exercises the timeout when ROUND_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_round_judge;

  localparam int WIDTH          = 4;
  localparam int NUM_ROUNDS     = 3;
  localparam int TIMEOUT_CYCLES = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             submit = 1'b0;
  logic [WIDTH-1:0] switches = '0;
  logic [WIDTH-1:0] target;
  logic             is_equal;
  logic             is_miss;
  logic             round_active;
  logic [3:0]       round_idx;
  logic             game_over;

  int tests = 0;
  int fails = 0;
  int eq_seen = 0;
  int miss_seen = 0;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  round_judge #(
    .WIDTH          (WIDTH),
    .NUM_ROUNDS     (NUM_ROUNDS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .submit       (submit),
    .switches     (switches),
    .target       (target),
    .is_equal     (is_equal),
    .is_miss      (is_miss),
    .round_active (round_active),
    .round_idx    (round_idx),
    .game_over    (game_over)
  );

  round_judge_checker #(.NUM_ROUNDS(NUM_ROUNDS)) u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .is_equal     (is_equal),
    .is_miss      (is_miss),
    .round_active (round_active),
    .game_over    (game_over),
    .round_idx    (round_idx)
  );

  // Reference random source: taps 16,14,13,11, seed ACE1, one step per clock.
  function automatic logic [15:0] model_step(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= model_step(m_lfsr);
  end

  // Pulse monitor: exclusivity plus running counts of judged outcomes.
  always @(negedge clk) begin
    if (rst_n && (is_equal || is_miss)) begin
      tests++;
      if (is_equal && is_miss) begin
        fails++;
        $display("FAIL pulse_exclusive: is_equal=%0b is_miss=%0b required not both", is_equal, is_miss);
      end
      if (is_equal) eq_seen++;
      if (is_miss) miss_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From IDLE/DONE: pulse start, return the target the DUT must load.
  task automatic begin_game(output logic [WIDTH-1:0] t);
    start = 1'b1;
    tick();
    start = 1'b0;
    t = m_lfsr[WIDTH-1:0];
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests++;
    if ({target, round_idx, is_equal, is_miss, round_active, game_over} !== 12'd0) begin
      fails++;
      $display("FAIL reset_hold: got %h required 0", {target, round_idx, is_equal, is_miss, round_active, game_over});
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if ({target, round_idx, is_equal, is_miss, round_active, game_over} !== 12'd0) begin
      fails++;
      $display("FAIL reset_release: got %h required 0", {target, round_idx, is_equal, is_miss, round_active, game_over});
    end
    switches = 4'd0;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    tests++;
    if ({is_equal, is_miss, round_active, round_idx} !== 7'd0) begin
      fails++;
      $display("FAIL idle_submit_ignored: got %h required 0", {is_equal, is_miss, round_active, round_idx});
    end
  endtask

  task automatic test_correct_guess();
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] t2;
    int d;
    repeat ($urandom_range(0, 3)) tick();
    begin_game(t);
    tests++;
    if ({round_active, target, round_idx, game_over} !== {1'b1, t, 4'd0, 1'b0}) begin
      fails++;
      $display("FAIL start_to_wait: got act=%0b tgt=%h idx=%0d over=%0b required act=1 tgt=%h idx=0 over=0",
               round_active, target, round_idx, game_over, t);
    end
    d = $urandom_range(1, 4);
    for (int i = 0; i < d; i++) begin
      start = (i == 0);
      tick();
      start = 1'b0;
    end
    tests++;
    if ({round_active, target} !== {1'b1, t}) begin
      fails++;
      $display("FAIL wait_start_ignored: got act=%0b tgt=%h required act=1 tgt=%h", round_active, target, t);
    end
    switches = t;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    tests++;
    if ({is_equal, is_miss, round_active} !== 3'b100) begin
      fails++;
      $display("FAIL hit_pulse: got eq=%0b miss=%0b act=%0b required eq=1 miss=0 act=0", is_equal, is_miss, round_active);
    end
    tick();
    t2 = m_lfsr[WIDTH-1:0];
    tests++;
    if ({is_equal, is_miss, round_idx} !== {2'b00, 4'd1}) begin
      fails++;
      $display("FAIL hit_after: got eq=%0b miss=%0b idx=%0d required eq=0 miss=0 idx=1", is_equal, is_miss, round_idx);
    end
    tick();
    tests++;
    if ({round_active, target} !== {1'b1, t2}) begin
      fails++;
      $display("FAIL next_round_target: got act=%0b tgt=%h required act=1 tgt=%h", round_active, target, t2);
    end
  endtask

  task automatic test_miss_game_end();
    logic [WIDTH-1:0] t;
    int eq0;
    int miss0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests++;
    if ({round_active, round_idx, game_over} !== 6'd0) begin
      fails++;
      $display("FAIL stop_from_wait: got act=%0b idx=%0d over=%0b required 0/0/0", round_active, round_idx, game_over);
    end
    eq0 = eq_seen;
    miss0 = miss_seen;
    begin_game(t);
    for (int r = 1; r <= NUM_ROUNDS; r++) begin
      repeat ($urandom_range(0, 3)) tick();
      switches = t ^ 4'($urandom_range(1, 15));
      submit = 1'b1;
      tick();
      submit = 1'b0;
      tests++;
      if ({is_equal, is_miss} !== 2'b01) begin
        fails++;
        $display("FAIL miss_pulse r%0d: got eq=%0b miss=%0b required eq=0 miss=1", r, is_equal, is_miss);
      end
      tick();
      tests++;
      if ({is_miss, round_idx} !== {1'b0, 4'(r)}) begin
        fails++;
        $display("FAIL miss_after r%0d: got miss=%0b idx=%0d required miss=0 idx=%0d", r, is_miss, round_idx, r);
      end
      if (r < NUM_ROUNDS) begin
        t = m_lfsr[WIDTH-1:0];
        tick();
        tests++;
        if ({round_active, target} !== {1'b1, t}) begin
          fails++;
          $display("FAIL miss_next r%0d: got act=%0b tgt=%h required act=1 tgt=%h", r, round_active, target, t);
        end
      end else begin
        tests++;
        if ({game_over, round_active} !== 2'b10) begin
          fails++;
          $display("FAIL game_over: got over=%0b act=%0b required over=1 act=0", game_over, round_active);
        end
      end
    end
    switches = t;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    tick();
    tests++;
    if ({game_over, round_idx, eq_seen - eq0, miss_seen - miss0} !== {1'b1, 4'd3, 32'd0, 32'd3}) begin
      fails++;
      $display("FAIL done_hold: got over=%0b idx=%0d hits=%0d misses=%0d required over=1 idx=3 hits=0 misses=3",
               game_over, round_idx, eq_seen - eq0, miss_seen - miss0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    t = m_lfsr[WIDTH-1:0];
    tests++;
    if ({round_idx, game_over, round_active} !== 6'd0) begin
      fails++;
      $display("FAIL restart_load: got idx=%0d over=%0b act=%0b required 0/0/0", round_idx, game_over, round_active);
    end
    tick();
    tests++;
    if ({round_active, target} !== {1'b1, t}) begin
      fails++;
      $display("FAIL restart_wait: got act=%0b tgt=%h required act=1 tgt=%h", round_active, target, t);
    end
  endtask

  task automatic test_abort();
    logic [WIDTH-1:0] t;
    t = target;
    switches = t;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests++;
    if ({is_equal, is_miss, round_idx, round_active, game_over, target} !== {8'd0, t}) begin
      fails++;
      $display("FAIL abort_judge: got eq=%0b miss=%0b idx=%0d act=%0b over=%0b tgt=%h required zeros tgt=%h",
               is_equal, is_miss, round_idx, round_active, game_over, target, t);
    end
    stop = 1'b1;
    start = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b0;
    tick();
    tests++;
    if ({round_active, round_idx, target} !== {5'd0, t}) begin
      fails++;
      $display("FAIL stop_priority: got act=%0b idx=%0d tgt=%h required act=0 idx=0 tgt=%h", round_active, round_idx, target, t);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] t;
    logic hit;
    int exp_eq;
    int exp_miss;
    int eq0;
    int miss0;
    exp_eq = 0;
    exp_miss = 0;
    eq0 = eq_seen;
    miss0 = miss_seen;
    for (int g = 0; g < 3; g++) begin
      begin_game(t);
      for (int r = 1; r <= NUM_ROUNDS; r++) begin
        repeat ($urandom_range(0, 2)) tick();
        hit = 1'($urandom_range(0, 1));
        switches = hit ? t : (t ^ 4'($urandom_range(1, 15)));
        if (hit) exp_eq++;
        else     exp_miss++;
        submit = 1'b1;
        tick();
        submit = 1'b0;
        tests++;
        if ({is_equal, is_miss} !== {hit, ~hit}) begin
          fails++;
          $display("FAIL rand_judge g%0d r%0d: got eq=%0b miss=%0b required eq=%0b miss=%0b", g, r, is_equal, is_miss, hit, ~hit);
        end
        tick();
        if (r < NUM_ROUNDS) begin
          t = m_lfsr[WIDTH-1:0];
          tick();
          tests++;
          if ({round_active, target, round_idx} !== {1'b1, t, 4'(r)}) begin
            fails++;
            $display("FAIL rand_next g%0d r%0d: got act=%0b tgt=%h idx=%0d required act=1 tgt=%h idx=%0d",
                     g, r, round_active, target, round_idx, t, r);
          end
        end
      end
      tests++;
      if ({game_over, round_idx} !== {1'b1, 4'd3}) begin
        fails++;
        $display("FAIL rand_done g%0d: got over=%0b idx=%0d required over=1 idx=3", g, game_over, round_idx);
      end
    end
    tests++;
    if ({eq_seen - eq0, miss_seen - miss0} !== {exp_eq, exp_miss}) begin
      fails++;
      $display("FAIL rand_counts: got hits=%0d misses=%0d required hits=%0d misses=%0d",
               eq_seen - eq0, miss_seen - miss0, exp_eq, exp_miss);
    end
  endtask

`ifdef ROUND_TIMEOUT_EN
  task automatic test_timeout();
    logic [WIDTH-1:0] t;
    begin_game(t);
    repeat (TIMEOUT_CYCLES - 1) tick();
    tests++;
    if ({round_active, is_miss} !== 2'b10) begin
      fails++;
      $display("FAIL timeout_early: got act=%0b miss=%0b required act=1 miss=0", round_active, is_miss);
    end
    tick();
    tests++;
    if ({is_miss, is_equal, round_idx} !== {2'b10, 4'd1}) begin
      fails++;
      $display("FAIL timeout_miss: got miss=%0b eq=%0b idx=%0d required miss=1 eq=0 idx=1", is_miss, is_equal, round_idx);
    end
    tick();
    t = m_lfsr[WIDTH-1:0];
    tick();
    repeat (TIMEOUT_CYCLES - 1) tick();
    switches = t;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    tests++;
    if ({is_equal, is_miss} !== 2'b10) begin
      fails++;
      $display("FAIL timeout_submit_wins: got eq=%0b miss=%0b required eq=1 miss=0", is_equal, is_miss);
    end
    tick();
    tick();
  endtask
`else
  task automatic test_timeout();
    logic [WIDTH-1:0] t;
    begin_game(t);
    repeat (TIMEOUT_CYCLES + 10) tick();
    tests++;
    if ({round_active, is_miss, is_equal, round_idx, target} !== {7'b1000000, t}) begin
      fails++;
      $display("FAIL wait_holds: got act=%0b miss=%0b eq=%0b idx=%0d tgt=%h required act=1 no pulse idx=0 tgt=%h",
               round_active, is_miss, is_equal, round_idx, target, t);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask
`endif

  task automatic test_async_reset();
    logic [WIDTH-1:0] t;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    begin_game(t);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({target, round_idx, is_equal, is_miss, round_active, game_over} !== 12'd0) begin
      fails++;
      $display("FAIL async_reset: got %h required 0", {target, round_idx, is_equal, is_miss, round_active, game_over});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    begin_game(t);
    tests++;
    if ({round_active, target} !== {1'b1, t}) begin
      fails++;
      $display("FAIL post_reset_game: got act=%0b tgt=%h required act=1 tgt=%h", round_active, target, t);
    end
  endtask

  initial begin
    test_reset();
    test_correct_guess();
    test_miss_game_end();
    test_abort();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
